// File: rtl/mic_clk_pkg.sv
// Shared types and constants for the acoustic-camera clock/reset sequencer.
// Holds the controller state encoding, default divider ratios and a counter-width helper.
package mic_clk_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        MIC_WAKE  = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int DIV_MIC_DEF     = 30;
    localparam int WS_DIV_DEF      = 64;
    localparam int LOCK_STABLE_DEF = 1024;
    localparam int WAKE_FRAMES_DEF = 16;

    // Bits needed to hold 0..n-1; never less than one so a count of 1 still gets a register.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for level signals crossing into the local clock domain.
// Output lags the input by two clock edges; reset forces both stages low.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mic_clk_sequencer.sv
// Clock/reset sequencer for the mic array: qualifies PLL lock, generates phase-locked
// mic bit clock and WS frame clock, and gates the datapath reset on whole-frame boundaries.
module mic_clk_sequencer
    import mic_clk_pkg::*;
#(
    parameter int DIV_MIC     = DIV_MIC_DEF,
    parameter int WS_DIV      = WS_DIV_DEF,
    parameter int LOCK_STABLE = LOCK_STABLE_DEF,
    parameter int WAKE_FRAMES = WAKE_FRAMES_DEF
) (
    input  logic   clk_in,
    input  logic   rst,
    input  logic   enable,
    input  logic   pll_lock,
    output logic   mic_clk,
    output logic   mic_rise_stb,
    output logic   ws,
    output logic   frame_stb,
    output logic   dp_rst,
    output logic   ready,
    output logic   lock_lost,
    output state_t state_dbg
);

    localparam int MIC_W  = clog2(DIV_MIC);
    localparam int BIT_W  = clog2(WS_DIV);
    localparam int STAB_W = clog2(LOCK_STABLE);
    localparam int FRM_W  = clog2(WAKE_FRAMES);

    localparam logic [MIC_W-1:0]  MIC_LAST  = MIC_W'(DIV_MIC - 1);
    localparam logic [MIC_W-1:0]  MIC_HALF  = MIC_W'(DIV_MIC / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WS_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_HALF  = BIT_W'(WS_DIV / 2);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(WAKE_FRAMES - 1);

    state_t              state;
    state_t              state_nxt;
    logic                lock_s;
    logic [MIC_W-1:0]    mic_cnt;
    logic [MIC_W-1:0]    mic_nxt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    bit_nxt;
    logic [STAB_W-1:0]   stab_cnt;
    logic [STAB_W-1:0]   stab_nxt;
    logic [FRM_W-1:0]    frm_cnt;
    logic [FRM_W-1:0]    frm_nxt;
    logic                mic_wrap;
    logic                frame_end;
    logic                run_cur;
    logic                run_nxt;
    logic                lost_set;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk_in),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign state_dbg = state;

    // Next-state and counter logic.
    always_comb begin
        state_nxt = state;
        stab_nxt  = '0;
        frm_nxt   = '0;
        lost_set  = 1'b0;
        mic_nxt   = '0;
        bit_nxt   = '0;
        mic_wrap  = (mic_cnt == MIC_LAST);
        frame_end = mic_wrap && (bit_cnt == BIT_LAST);
        run_cur   = (state == MIC_WAKE) || (state == RUN);

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (lock_s) begin
                    if (stab_cnt == STAB_LAST) begin
                        state_nxt = MIC_WAKE;
                    end else begin
                        stab_nxt = stab_cnt + 1'b1;
                    end
                end
            end
            MIC_WAKE: begin
                frm_nxt = frm_cnt;
                // Lock loss outranks a stop request so the fault is always recorded.
                if (!lock_s) begin
                    state_nxt = FAULT;
                    lost_set  = 1'b1;
                end else if (!enable) begin
                    state_nxt = IDLE;
                end else if (frame_end) begin
                    if (frm_cnt == FRM_LAST) begin
                        state_nxt = RUN;
                        frm_nxt   = '0;
                    end else begin
                        frm_nxt = frm_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = FAULT;
                    lost_set  = 1'b1;
                end else if (!enable && frame_end) begin
                    state_nxt = IDLE;
                end
            end
            FAULT: begin
                state_nxt = WAIT_LOCK;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        run_nxt = (state_nxt == MIC_WAKE) || (state_nxt == RUN);

        // Dividers free-run only while staying in a clocked state; entry starts at 0/0.
        if (run_cur && run_nxt) begin
            mic_nxt = mic_wrap ? '0 : mic_cnt + 1'b1;
            if (mic_wrap) begin
                bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end else begin
                bit_nxt = bit_cnt;
            end
        end
    end

    // Outputs are registered from the next counter values so they line up with the counters.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= IDLE;
            mic_cnt      <= '0;
            bit_cnt      <= '0;
            stab_cnt     <= '0;
            frm_cnt      <= '0;
            mic_clk      <= 1'b0;
            mic_rise_stb <= 1'b0;
            ws           <= 1'b0;
            frame_stb    <= 1'b0;
            dp_rst       <= 1'b1;
            ready        <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            state        <= state_nxt;
            mic_cnt      <= mic_nxt;
            bit_cnt      <= bit_nxt;
            stab_cnt     <= stab_nxt;
            frm_cnt      <= frm_nxt;
            mic_clk      <= run_nxt && (mic_nxt < MIC_HALF);
            mic_rise_stb <= run_nxt && (mic_nxt == '0);
            ws           <= run_nxt && (bit_nxt < BIT_HALF);
            frame_stb    <= run_nxt && (mic_nxt == '0) && (bit_nxt == '0);
            dp_rst       <= (state_nxt != RUN);
            ready        <= (state_nxt == RUN);
            if (lost_set) begin
                lock_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mic_clk_sequencer.sv
// Directed bench for mic_clk_sequencer with DIV_MIC=4, WS_DIV=8, LOCK_STABLE=16, WAKE_FRAMES=2.
// Expected latencies and waveforms are worked out by hand from the sequencer rules.
module tb_mic_clk_sequencer;
    import mic_clk_pkg::*;

    logic   clk_in = 1'b0;
    logic   rst;
    logic   enable;
    logic   pll_lock;
    logic   mic_clk;
    logic   mic_rise_stb;
    logic   ws;
    logic   frame_stb;
    logic   dp_rst;
    logic   ready;
    logic   lock_lost;
    state_t state_dbg;

    int vectors     = 0;
    int miscompares = 0;

    mic_clk_sequencer #(
        .DIV_MIC     (4),
        .WS_DIV      (8),
        .LOCK_STABLE (16),
        .WAKE_FRAMES (2)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .pll_lock     (pll_lock),
        .mic_clk      (mic_clk),
        .mic_rise_stb (mic_rise_stb),
        .ws           (ws),
        .frame_stb    (frame_stb),
        .dp_rst       (dp_rst),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .state_dbg    (state_dbg)
    );

    // Clock and watchdog.
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_state(input state_t tgt, input int budget, output int n);
        n = 0;
        while (state_dbg != tgt && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},     32'(state_dbg),    32'(IDLE));
        check({tag, "_mic_clk"},   32'(mic_clk),      32'd0);
        check({tag, "_mic_rise"},  32'(mic_rise_stb), 32'd0);
        check({tag, "_ws"},        32'(ws),           32'd0);
        check({tag, "_frame"},     32'(frame_stb),    32'd0);
        check({tag, "_dp_rst"},    32'(dp_rst),       32'd1);
        check({tag, "_ready"},     32'(ready),        32'd0);
        check({tag, "_lock_lost"}, 32'(lock_lost),    32'd0);
    endtask

    int  n;
    int  frames;
    logic mic_seen;

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        pll_lock = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");

        // 1: lock qualifies, wake for two frames, then RUN.
        enable   = 1'b1;
        pll_lock = 1'b1;
        rst      = 1'b0;
        tick();
        check("s1_wait_lock", 32'(state_dbg), 32'(WAIT_LOCK));
        // lock_s high after 2 edges; 16 qualifying samples follow.
        wait_state(MIC_WAKE, 100, n);
        check("s1_wake_latency", n, 17);
        for (int i = 0; i < 64; i++) begin
            check("s1_state",    32'(state_dbg),    32'(MIC_WAKE));
            check("s1_mic_clk",  32'(mic_clk),      32'((i % 4) < 2));
            check("s1_mic_rise", 32'(mic_rise_stb), 32'((i % 4) == 0));
            check("s1_ws",       32'(ws),           32'(((i / 4) % 8) < 4));
            check("s1_frame",    32'(frame_stb),    32'((i % 32) == 0));
            check("s1_dp_rst",   32'(dp_rst),       32'd1);
            check("s1_ready",    32'(ready),        32'd0);
            tick();
        end
        check("s1_run",        32'(state_dbg), 32'(RUN));
        check("s1_run_ready",  32'(ready),     32'd1);
        check("s1_run_dp_rst", 32'(dp_rst),    32'd0);
        check("s1_run_frame",  32'(frame_stb), 32'd1);
        check("s1_run_mic",    32'(mic_clk),   32'd1);

        // 3: one-cycle lock drop in RUN.
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        check("s3_h0_run", 32'(state_dbg), 32'(RUN));
        tick();
        check("s3_h1_run",   32'(state_dbg), 32'(RUN));
        check("s3_h1_ready", 32'(ready),     32'd1);
        tick();
        check("s3_fault",      32'(state_dbg), 32'(FAULT));
        check("s3_lock_lost",  32'(lock_lost), 32'd1);
        check("s3_dp_rst",     32'(dp_rst),    32'd1);
        check("s3_ready",      32'(ready),     32'd0);
        check("s3_mic_clk",    32'(mic_clk),   32'd0);
        check("s3_ws",         32'(ws),        32'd0);
        check("s3_frame",      32'(frame_stb), 32'd0);
        tick();
        check("s3_relock", 32'(state_dbg), 32'(WAIT_LOCK));
        wait_state(MIC_WAKE, 100, n);
        check("s3_wake_latency", n, 16);
        wait_state(RUN, 200, n);
        check("s3_run_latency", n, 64);
        check("s3_lost_sticky", 32'(lock_lost), 32'd1);

        // 4: graceful stop mid-frame (stop sampled at bit 3).
        frames = frame_stb ? 1 : 0;
        repeat (13) begin
            tick();
            if (frame_stb) frames++;
        end
        check("s4_ws_bit3", 32'(ws), 32'd1);
        enable = 1'b0;
        repeat (18) begin
            tick();
            if (frame_stb) frames++;
        end
        check("s4_last_run", 32'(state_dbg), 32'(RUN));
        check("s4_last_ws",  32'(ws),        32'd0);
        check("s4_last_mic", 32'(mic_clk),   32'd0);
        tick();
        if (frame_stb) frames++;
        check("s4_idle",     32'(state_dbg), 32'(IDLE));
        check("s4_dp_rst",   32'(dp_rst),    32'd1);
        check("s4_ready",    32'(ready),     32'd0);
        check("s4_frames",   frames,         1);
        check("s4_lost",     32'(lock_lost), 32'd1);

        // 6: rst pulse mid-frame in RUN.
        enable = 1'b1;
        tick();
        wait_state(MIC_WAKE, 100, n);
        check("s6_wake_latency", n, 16);
        wait_state(RUN, 200, n);
        check("s6_run_latency", n, 64);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("s6_rst");
        rst = 1'b0;
        tick();
        check("s6_wait_lock", 32'(state_dbg), 32'(WAIT_LOCK));
        wait_state(MIC_WAKE, 100, n);
        check("s6_relock_latency", n, 17);
        wait_state(RUN, 200, n);
        check("s6_rerun_latency", n, 64);

        // 5: stop and lock loss land on the same cycle.
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        check("s5_k1_run",  32'(state_dbg), 32'(RUN));
        check("s5_k1_lost", 32'(lock_lost), 32'd0);
        enable = 1'b0;
        tick();
        check("s5_fault",  32'(state_dbg), 32'(FAULT));
        check("s5_lost",   32'(lock_lost), 32'd1);
        check("s5_dp_rst", 32'(dp_rst),    32'd1);
        check("s5_ready",  32'(ready),     32'd0);
        tick();
        check("s5_wait_lock", 32'(state_dbg), 32'(WAIT_LOCK));
        tick();
        check("s5_idle", 32'(state_dbg), 32'(IDLE));

        // 2: lock chatter while waiting for lock.
        pll_lock = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        tick();
        check("s2_wait_lock", 32'(state_dbg), 32'(WAIT_LOCK));
        mic_seen = 1'b0;
        repeat (4) begin
            tick();
            mic_seen = mic_seen | mic_clk;
        end
        pll_lock = 1'b1;
        repeat (10) begin
            tick();
            mic_seen = mic_seen | mic_clk;
        end
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        check("s2_still_waiting", 32'(state_dbg), 32'(WAIT_LOCK));
        n = 0;
        while (state_dbg != MIC_WAKE && n < 100) begin
            tick();
            n++;
            if (state_dbg != MIC_WAKE) mic_seen = mic_seen | mic_clk;
        end
        check("s2_wake_latency", n, 18);
        check("s2_mic_quiet",    32'(mic_seen), 32'd0);
        check("s2_first_rise",   32'(mic_rise_stb), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
